// File: rtl/warp_scheduler_pkg.sv
// rtl/warp_scheduler_pkg.sv - shared warp-state encoding and default sizes for the warp scheduler
package warp_scheduler_pkg;

  localparam int DEF_NUM_WARP     = 8;
  localparam int DEF_NUM_WARP_LOG = 3;
  localparam int STATE_W          = 2;

  typedef enum logic [STATE_W-1:0] {
    WS_IDLE    = 2'd0,
    WS_READY   = 2'd1,
    WS_BARRIER = 2'd2,
    WS_EXITED  = 2'd3
  } warp_state_e;

endpackage

// File: rtl/warp_scheduler_if.sv
// rtl/warp_scheduler_if.sv - feedback/launch inputs and grant outputs of the warp scheduler
interface warp_scheduler_if
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARP     = DEF_NUM_WARP,
  parameter int NUM_WARP_LOG = DEF_NUM_WARP_LOG
);

  logic                        launch_i;
  logic [NUM_WARP-1:0]         launchMask_i;
  logic [NUM_WARP-1:0]         warpReady_i;
  logic                        stall_i;
  logic                        issuedValid_i;
  logic [NUM_WARP_LOG-1:0]     issuedWarp_i;
  logic                        issuedSync_i;
  logic                        issuedExit_i;
  logic [NUM_WARP_LOG-1:0]     selectedWarp_o;
  logic                        selectedValid_o;
  logic [STATE_W*NUM_WARP-1:0] warpState_o;
  logic                        done_o;

  modport master (
    output launch_i, launchMask_i, warpReady_i, stall_i,
           issuedValid_i, issuedWarp_i, issuedSync_i, issuedExit_i,
    input  selectedWarp_o, selectedValid_o, warpState_o, done_o
  );

  modport slave (
    input  launch_i, launchMask_i, warpReady_i, stall_i,
           issuedValid_i, issuedWarp_i, issuedSync_i, issuedExit_i,
    output selectedWarp_o, selectedValid_o, warpState_o, done_o
  );

endinterface

// File: rtl/warp_scheduler_rr_arbiter.sv
// rtl/warp_scheduler_rr_arbiter.sv - combinational N-way round-robin picker starting after the pointer
module rr_arbiter #(
  parameter int N   = 8,
  parameter int LOG = 3
) (
  input  logic [N-1:0]   i_req,
  input  logic [LOG-1:0] i_ptr,
  output logic [LOG-1:0] o_grant_idx,
  output logic           o_grant_valid
);

  logic [LOG-1:0] w_idx;

  // Offsets 1..N; offset N wraps onto the pointer itself, so it is searched last.
  always_comb begin
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_idx         = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = i_ptr + LOG'(i);
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_idx   = w_idx;
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - per-warp lifecycle tracking with round-robin issue selection and barrier release
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARP     = DEF_NUM_WARP,
  parameter int NUM_WARP_LOG = DEF_NUM_WARP_LOG
) (
  input logic             clk,
  input logic             reset,
  warp_scheduler_if.slave bus
);

  generate
    if ((NUM_WARP < 2) || ((NUM_WARP & (NUM_WARP - 1)) != 0) || ((1 << NUM_WARP_LOG) != NUM_WARP)) begin : g_bad_size
      $error("warp_scheduler: NUM_WARP must be a power of two equal to 2**NUM_WARP_LOG");
    end
  endgenerate

  warp_state_e               r_state     [NUM_WARP];
  warp_state_e               w_state_nxt [NUM_WARP];
  logic [NUM_WARP_LOG-1:0]   r_ptr;

  logic [NUM_WARP-1:0]       w_is_ready;
  logic [NUM_WARP-1:0]       w_is_barrier;
  logic [NUM_WARP-1:0]       w_eligible;
  logic [NUM_WARP_LOG-1:0]   w_grant_idx;
  logic                      w_grant_any;
  logic                      w_sel_valid;
  logic                      w_release;
  logic [STATE_W*NUM_WARP-1:0] w_state_packed;

  always_comb begin
    w_is_ready     = '0;
    w_is_barrier   = '0;
    w_eligible     = '0;
    w_state_packed = '0;
    for (int w = 0; w < NUM_WARP; w++) begin
      w_is_ready[w]                 = (r_state[w] == WS_READY);
      w_is_barrier[w]               = (r_state[w] == WS_BARRIER);
      w_eligible[w]                 = w_is_ready[w] && bus.warpReady_i[w];
      w_state_packed[w*STATE_W +: STATE_W] = r_state[w];
    end
  end

  // Barrier drains only once nobody can still reach the sync: exited and idle warps don't block it.
  assign w_release = (|w_is_barrier) && !(|w_is_ready);

  rr_arbiter #(
    .N   (NUM_WARP),
    .LOG (NUM_WARP_LOG)
  ) u_arb (
    .i_req         (w_eligible),
    .i_ptr         (r_ptr),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_any)
  );

  assign w_sel_valid         = w_grant_any && !bus.stall_i;
  assign bus.selectedValid_o = w_sel_valid;
  assign bus.selectedWarp_o  = w_grant_idx;
  assign bus.warpState_o     = w_state_packed;
  assign bus.done_o          = !((|w_is_ready) || (|w_is_barrier));

  // Feedback only touches READY warps and launch only IDLE/EXITED ones, so the cases never collide.
  always_comb begin
    for (int w = 0; w < NUM_WARP; w++) begin
      w_state_nxt[w] = r_state[w];
      case (r_state[w])
        WS_READY: begin
          if (bus.issuedValid_i && (bus.issuedWarp_i == NUM_WARP_LOG'(w))) begin
            if (bus.issuedExit_i) begin
              w_state_nxt[w] = WS_EXITED;
            end else if (bus.issuedSync_i) begin
              w_state_nxt[w] = WS_BARRIER;
            end
          end
        end
        WS_BARRIER: begin
          if (w_release) begin
            w_state_nxt[w] = WS_READY;
          end
        end
        default: begin
          if (bus.launch_i && bus.launchMask_i[w]) begin
            w_state_nxt[w] = WS_READY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARP; w++) begin
        r_state[w] <= WS_IDLE;
      end
      r_ptr <= NUM_WARP_LOG'(NUM_WARP - 1);
    end else begin
      for (int w = 0; w < NUM_WARP; w++) begin
        r_state[w] <= w_state_nxt[w];
      end
      if (w_sel_valid) begin
        r_ptr <= w_grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - directed vector table and corner sequences for warp_scheduler
module tb_warp_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  warp_scheduler_if #(.NUM_WARP(8), .NUM_WARP_LOG(3)) bus ();

  warp_scheduler #(.NUM_WARP(8), .NUM_WARP_LOG(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        launch;
    logic [7:0]  mask;
    logic [7:0]  ready;
    logic        stall;
    logic        iv;
    logic [2:0]  iw;
    logic        isync;
    logic        iexit;
    logic        exp_valid;
    logic [2:0]  exp_warp;
    logic        chk_warp;
    logic [15:0] exp_state;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic launch, input logic [7:0] mask, input logic [7:0] ready,
                              input logic stall, input logic iv, input logic [2:0] iw,
                              input logic isync, input logic iexit, input logic ev,
                              input logic [2:0] ew, input logic cw, input logic [15:0] es,
                              input logic ed);
    vec_t v;
    v.launch = launch; v.mask = mask; v.ready = ready; v.stall = stall;
    v.iv = iv; v.iw = iw; v.isync = isync; v.iexit = iexit;
    v.exp_valid = ev; v.exp_warp = ew; v.chk_warp = cw; v.exp_state = es; v.exp_done = ed;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic launch, input logic [7:0] mask, input logic [7:0] ready,
                       input logic stall, input logic iv, input logic [2:0] iw,
                       input logic isync, input logic iexit);
    bus.launch_i      = launch;
    bus.launchMask_i  = mask;
    bus.warpReady_i   = ready;
    bus.stall_i       = stall;
    bus.issuedValid_i = iv;
    bus.issuedWarp_i  = iw;
    bus.issuedSync_i  = isync;
    bus.issuedExit_i  = iexit;
  endtask

  task automatic check_outputs(input string tag, input int idx, input logic ev, input logic [2:0] ew,
                               input logic cw, input logic [15:0] es, input logic ed);
    chk({tag, "_valid"}, idx, 16'(bus.selectedValid_o), 16'(ev));
    if (cw) chk({tag, "_warp"}, idx, 16'(bus.selectedWarp_o), 16'(ew));
    chk({tag, "_state"}, idx, bus.warpState_o, es);
    chk({tag, "_done"}, idx, 16'(bus.done_o), 16'(ed));
  endtask

  // Stimulus sanity: Issue must never report feedback for a warp that is not READY.
  always @(posedge clk) begin
    if (!reset && bus.issuedValid_i && (bus.warpState_o[int'(bus.issuedWarp_i)*2 +: 2] != 2'd1)) begin
      errors++;
      $display("FAIL fb_not_ready: warp %0d state %0d required 1", bus.issuedWarp_i,
               bus.warpState_o[int'(bus.issuedWarp_i)*2 +: 2]);
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0);

    //        launch mask   ready  stl iv iw  syn ex  val warp cw state    done
    // round robin over 0..3
    vecs.push_back(mk(1, 8'h0F, 8'hFF, 0, 0, 3'd0, 0, 0, 0, 3'd0, 1, 16'h0000, 1));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 1, 3'd0, 1, 16'h0055, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 1, 3'd1, 1, 16'h0055, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 1, 3'd2, 1, 16'h0055, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 1, 3'd3, 1, 16'h0055, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 1, 3'd0, 1, 16'h0055, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 1, 3'd1, 1, 16'h0055, 0));
    // two stall cycles, then grant 2 shows the pointer held
    vecs.push_back(mk(0, 8'h00, 8'hFF, 1, 0, 3'd0, 0, 0, 0, 3'd0, 0, 16'h0055, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 1, 0, 3'd0, 0, 0, 0, 3'd0, 0, 16'h0055, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 1, 3'd2, 1, 16'h0055, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 1, 3'd3, 1, 16'h0055, 0));
    // barrier: sync 1,0,2,3; bubble; release; grant 0
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 3'd1, 1, 0, 1, 3'd0, 1, 16'h0055, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 3'd0, 1, 0, 1, 3'd2, 1, 16'h0059, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 3'd2, 1, 0, 1, 3'd3, 1, 16'h005A, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 3'd3, 1, 0, 1, 3'd3, 1, 16'h006A, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 0, 3'd0, 1, 16'h00AA, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 1, 3'd0, 1, 16'h0055, 0));
    // exit releases barrier: exit 3, sync 0 and 1, exit 2
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 3'd3, 0, 1, 1, 3'd1, 1, 16'h0055, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 3'd0, 1, 0, 1, 3'd2, 1, 16'h00D5, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 3'd1, 1, 0, 1, 3'd1, 1, 16'h00D6, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 3'd2, 0, 1, 1, 3'd2, 1, 16'h00DA, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 0, 3'd0, 1, 16'h00FA, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 1, 3'd0, 1, 16'h00F5, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 1, 3'd1, 1, 16'h00F5, 0));
    // all exit -> done; relaunch 0x03; redundant launch of READY warp 0
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 3'd0, 0, 1, 1, 3'd0, 1, 16'h00F5, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 3'd1, 0, 1, 1, 3'd1, 1, 16'h00F7, 0));
    vecs.push_back(mk(1, 8'h03, 8'hFF, 0, 0, 3'd0, 0, 0, 0, 3'd0, 1, 16'h00FF, 1));
    vecs.push_back(mk(1, 8'h01, 8'hFF, 0, 0, 3'd0, 0, 0, 1, 3'd0, 1, 16'h00F5, 0));
    // exit wins over sync on warp 1; warp 0 parks at barrier
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 3'd1, 1, 1, 1, 3'd1, 1, 16'h00F5, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 1, 3'd0, 1, 0, 1, 3'd0, 1, 16'h00FD, 0));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0, 0, 3'd0, 1, 16'h00FE, 0));

    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset", 0, 1'b0, 3'd0, 1'b1, 16'h0000, 1'b1);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].launch, vecs[i].mask, vecs[i].ready, vecs[i].stall,
            vecs[i].iv, vecs[i].iw, vecs[i].isync, vecs[i].iexit);
      #1;
      check_outputs("vec", i, vecs[i].exp_valid, vecs[i].exp_warp, vecs[i].chk_warp,
                    vecs[i].exp_state, vecs[i].exp_done);
    end

    // Reset while warp 0 sits at BARRIER; launch and feedback in that cycle are discarded.
    @(negedge clk);
    reset = 1'b1;
    drive(1, 8'hFF, 8'hFF, 0, 0, 3'd0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 8'h0F, 8'hFF, 0, 0, 3'd0, 0, 0);
    #1;
    check_outputs("midreset", 0, 1'b0, 3'd0, 1'b1, 16'h0000, 1'b1);
    @(negedge clk);
    drive(0, 8'h00, 8'hFF, 0, 0, 3'd0, 0, 0);
    #1;
    check_outputs("relaunch", 0, 1'b1, 3'd0, 1'b1, 16'h0055, 1'b0);

    // Only warps 1 and 3 have packets ready: grants alternate between them.
    @(negedge clk);
    drive(0, 8'h00, 8'h0A, 0, 0, 3'd0, 0, 0);
    #1;
    check_outputs("partial", 0, 1'b1, 3'd1, 1'b1, 16'h0055, 1'b0);
    @(negedge clk);
    #1;
    check_outputs("partial", 1, 1'b1, 3'd3, 1'b1, 16'h0055, 1'b0);
    @(negedge clk);
    #1;
    check_outputs("partial", 2, 1'b1, 3'd1, 1'b1, 16'h0055, 1'b0);

    // Ready warps with no packet: nothing granted, warp output reads 0.
    @(negedge clk);
    drive(0, 8'h00, 8'hF0, 0, 0, 3'd0, 0, 0);
    #1;
    check_outputs("noready", 0, 1'b0, 3'd0, 1'b1, 16'h0055, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
